// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings and constants for the EX-stage multiply/divide unit.
// Rev 1.0 - initial release.
`default_nettype none

package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         ITERATIONS = 32;
    localparam logic [4:0] CNT_LAST   = 5'(ITERATIONS - 1);

    // Absolute value when the operand is treated as signed; raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_div_core.sv
// div_core: 32-iteration restoring divider with sign fix-up and divide-by-zero result.
// Rev 1.0 - initial release.
`default_nettype none

module div_core
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [31:0] r_a_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic [32:0] w_shift;
    logic        w_fit;
    logic [31:0] w_sub;

    // Partial remainder stays below the divisor, so the low 32 bits of the
    // subtraction are exact whenever the trial fits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_fit   = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[31:0] - r_dvs;

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_dvs   <= 32'd0;
            r_a_raw <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= 5'd0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_quo   <= mag32(i_dividend, i_signed);
            r_rem   <= 32'd0;
            r_dvs   <= mag32(i_divisor, i_signed);
            r_a_raw <= i_dividend;
            r_neg_q <= i_signed & (i_dividend[31] ^ i_divisor[31]);
            r_neg_r <= i_signed & i_dividend[31];
            r_dz    <= (i_divisor == 32'd0);
        end else if (r_busy) begin
            r_rem <= w_fit ? w_sub : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_fit};
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign o_done      = r_busy && (r_cnt == CNT_LAST) && !i_abort;
    assign o_quotient  = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (~r_quo + 32'd1) : r_quo);
    assign o_remainder = r_dz ? r_a_raw       : (r_neg_r ? (~r_rem + 32'd1) : r_rem);

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage HI/LO multiply/divide unit with pipeline stall and flush.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier. Rev 1.0.
`default_nettype none

module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rset,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] value_A_in,
    input  logic [31:0] value_B_in,
    input  logic        flush_in,
    output logic        stall_req_out,
    output logic        hilo_we_out,
    output logic [63:0] HILO_out,
    output logic        busy_out
);

    state_e      r_state;
    state_e      w_next;
    logic [4:0]  r_cnt;
    op_e         r_op;
    logic [63:0] r_prod;
    logic        r_mul_neg;
    logic [63:0] r_hilo;

    logic        w_start_ok;
    logic        w_op_is_div;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_result;
    logic        w_show;

    assign w_start_ok  = (r_state == ST_IDLE) && start_in && !flush_in;
    assign w_op_is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);

    div_core u_div_core (
        .clk         (clk),
        .rset        (rset),
        .i_start     (w_start_ok && w_op_is_div),
        .i_abort     (flush_in),
        .i_signed    (op_in == OP_DIV),
        .i_dividend  (value_A_in),
        .i_divisor   (value_B_in),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_a;
    logic [63:0] w_fast_b;
    logic [63:0] w_fast_prod;

    // Sign/zero extension to 64 bits yields the low 64 bits of the 33x33 signed product.
    assign w_fast_a    = {{32{(op_in == OP_MULT) & value_A_in[31]}}, value_A_in};
    assign w_fast_b    = {{32{(op_in == OP_MULT) & value_B_in[31]}}, value_B_in};
    assign w_fast_prod = w_fast_a * w_fast_b;
`else
    logic [31:0] r_mcand;
    logic [32:0] w_sum;

    assign w_sum = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
`endif

    always_comb begin
        w_next        = r_state;
        stall_req_out = 1'b0;
        hilo_we_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    stall_req_out = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                    w_next = w_op_is_div ? ST_DIV : ST_DONE;
`else
                    w_next = w_op_is_div ? ST_DIV : ST_MUL;
`endif
                end
            end
            ST_MUL: begin
                stall_req_out = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next = ST_DONE;
                end
            end
            ST_DIV: begin
                stall_req_out = 1'b1;
                if (w_div_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                hilo_we_out = !flush_in;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (flush_in) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_cnt     <= 5'd0;
            r_op      <= OP_MULT;
            r_prod    <= 64'd0;
            r_mul_neg <= 1'b0;
            r_hilo    <= 64'd0;
`ifndef MULDIV_FAST_MUL_EN
            r_mcand   <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_start_ok) begin
                        r_op <= op_e'(op_in);
                        if (!w_op_is_div) begin
`ifdef MULDIV_FAST_MUL_EN
                            r_prod    <= w_fast_prod;
                            r_mul_neg <= 1'b0;
`else
                            r_mcand   <= mag32(value_A_in, op_in == OP_MULT);
                            r_prod    <= {32'd0, mag32(value_B_in, op_in == OP_MULT)};
                            r_mul_neg <= (op_in == OP_MULT) & (value_A_in[31] ^ value_B_in[31]);
`endif
                        end
                    end
                end
                ST_MUL: begin
`ifndef MULDIV_FAST_MUL_EN
                    r_prod <= {w_sum, r_prod[31:1]};
`endif
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (!flush_in) begin
                        r_hilo <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_result = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? {w_rem, w_quo}
                    : (r_mul_neg ? (~r_prod + 64'd1) : r_prod);

    // The fresh result is visible during DONE; afterwards the captured copy holds.
    assign w_show   = (r_state == ST_DONE) && !flush_in;
    assign HILO_out = w_show ? w_result : r_hilo;
    assign busy_out = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv.
`default_nettype none

module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rset = 1'b0;
    logic        start_in = 1'b0;
    logic [1:0]  op_in = 2'd0;
    logic [31:0] value_A_in = 32'd0;
    logic [31:0] value_B_in = 32'd0;
    logic        flush_in = 1'b0;
    logic        stall_req_out;
    logic        hilo_we_out;
    logic [63:0] HILO_out;
    logic        busy_out;

    int n_pass  = 0;
    int n_total = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    ex_muldiv dut (
        .clk           (clk),
        .rset          (rset),
        .start_in      (start_in),
        .op_in         (op_in),
        .value_A_in    (value_A_in),
        .value_B_in    (value_B_in),
        .flush_in      (flush_in),
        .stall_req_out (stall_req_out),
        .hilo_we_out   (hilo_we_out),
        .HILO_out      (HILO_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int cyc;
        bit stall_ok;
        bit seen;
        @(negedge clk);
        start_in   = 1'b1;
        op_in      = op;
        value_A_in = a;
        value_B_in = b;
        #1 check({tag, "_stall_start"}, 64'(stall_req_out), 64'd1);
        cyc      = 0;
        stall_ok = 1'b1;
        seen     = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start_in   = (cyc == 5 && exp_lat > 5);
            value_A_in = ~a;
            value_B_in = ~b;
            #1;
            if (hilo_we_out) seen = 1'b1;
            else if (!stall_req_out) stall_ok = 1'b0;
        end
        start_in = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
        check({tag, "_result"}, HILO_out, exp);
        check({tag, "_stall_done"}, 64'(stall_req_out), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_hold"}, HILO_out, exp);
        check({tag, "_we_off"}, 64'(hilo_we_out), 64'd0);
        check({tag, "_idle"}, 64'(busy_out), 64'd0);
    endtask

    initial begin
        bit we_seen;
        #1;
        check("rst_hilo", HILO_out, 64'd0);
        check("rst_we", 64'(hilo_we_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_stall", 64'(stall_req_out), 64'd0);
        repeat (2) @(negedge clk);
        rset = 1'b1;

        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run_op("mult_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, MUL_LAT);
        run_op("multu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
        run_op("mult_m3_7", 2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        run_op("divu_5_0", 2'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 33);
        run_op("div_m7_0", 2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 33);

        // Flush a DIV at cycle 10; previous result {-7, all ones} must persist.
        @(negedge clk);
        start_in = 1'b1; op_in = 2'd2; value_A_in = 32'd1000; value_B_in = 32'd3;
        we_seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_in = 1'b0;
            #1 if (hilo_we_out) we_seen = 1'b1;
        end
        flush_in = 1'b1;
        #1 check("flush_we_c10", 64'(hilo_we_out), 64'd0);
        @(negedge clk);
        flush_in = 1'b0;
        #1 check("flush_idle_c11", 64'(busy_out), 64'd0);
        for (int c = 12; c <= 40; c++) begin
            @(negedge clk);
            #1 if (hilo_we_out) we_seen = 1'b1;
        end
        check("flush_no_we", 64'(we_seen), 64'd0);
        check("flush_hilo_kept", HILO_out, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op("divu_9_3", 2'd3, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Asynchronous reset in the middle of a MULTU.
        @(negedge clk);
        start_in = 1'b1; op_in = 2'd1; value_A_in = 32'd12345; value_B_in = 32'd678;
        @(negedge clk);
        start_in = 1'b0;
        repeat (19) @(negedge clk);
        #2 rset = 1'b0;
        #1;
        check("arst_hilo", HILO_out, 64'd0);
        check("arst_busy", 64'(busy_out), 64'd0);
        check("arst_we", 64'(hilo_we_out), 64'd0);
        check("arst_stall", 64'(stall_req_out), 64'd0);
        @(negedge clk);
        rset = 1'b1;
        run_op("multu_after_rst", 2'd1, 32'd12345, 32'd678, 64'd8369910, MUL_LAT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does:
- `clk`  in  1  rising-edge clock.
- `rset`  in  1  asynchronous active-low reset.
REQ-002 SHALL expose these ports, after clock and reset:
- `start_in`  in  1  EX holds a MULT/MULTU/DIV/DIVU this cycle.
- `op_in`  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `value_A_in`  in  32  rs operand (dividend / multiplicand).
- `value_B_in`  in  32  rt operand (divisor / multiplier).
- `flush_in`  in  1  exception/eret flush of EX.
- `stall_req_out`  out  1  request pipeline hold (IF..EX).
- `hilo_we_out`  out  1  one-cycle HI/LO write strobe.
- `HILO_out`  out  64  result, {HI,LO}.
- `busy_out`  out  1  unit not in IDLE.

Function
REQ-003 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-004 In IDLE with `start_in`=1 and `flush_in`=0, SHALL latch the operands and `op_in`, then go to MUL (op 0/1) or DIV (op 2/3).
REQ-005 `stall_req_out` SHALL equal (IDLE & `start_in` & !`flush_in`) | MUL | DIV, combinationally; it SHALL be 0 in DONE, so the instruction leaves EX on the DONE cycle.
REQ-006 Iterative multiply SHALL be shift-add: 32 cycles in MUL, then DONE. Signed operands SHALL be handled by magnitude plus final negation of the 64-bit product.
REQ-007 Divide SHALL be restoring: 32 cycles in DIV, then DONE. Quotient to LO, remainder to HI.
REQ-008 Signed divide: quotient is negative iff operand signs differ; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-009 Divide by zero SHALL complete in the normal latency with LO=0xFFFFFFFF, HI=`value_A` (signed and unsigned alike).
REQ-010 In DONE, `hilo_we_out`=1 and `HILO_out` holds the result for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-011 `HILO_out` SHALL hold its last result in IDLE.
REQ-012 Total latency, start to `hilo_we_out`: 33 cycles (iterative multiply and divide).
REQ-013 `flush_in`=1 in any state SHALL force IDLE on the next edge with `hilo_we_out`=0; flush has priority over DONE and over `start_in`.
REQ-014 `start_in` outside IDLE SHALL be ignored; operand changes after latching SHALL NOT affect the result.
REQ-015 The iteration counter SHALL be 5 bits, counting 0..31 and terminating at 31, with no wrap into another pass.

Reset
REQ-016 While `rset`=0, asynchronously: state=IDLE, counter=0, `HILO_out`=0, `hilo_we_out`=0, `busy_out`=0, internal operand registers=0; `stall_req_out`=0 because `start_in` is gated by IDLE logic only after reset release.
REQ-017 Reset asserted mid-operation SHALL abandon the operation with no HI/LO write.

Configuration
REQ-018 Macro `MULDIV_FAST_MUL_EN`:
- Defined: MULT/MULTU SHALL use a single combinational 33x33 signed product, and IDLE SHALL go directly to DONE (latency 1 cycle, `stall_req_out`=1 only during the start cycle).
- Undefined: the 32-cycle shift-add of REQ-006 applies.
- Divide behaviour SHALL be identical either way.

Structure
REQ-019 Shared package SHALL hold the `op` encodings (MULT/MULTU/DIV/DIVU), the state enum, and the iteration constant 32.
REQ-020 Divide datapath SHALL be a sub-module `div_core`, with start/abort/done, operands in, and quotient/remainder out; the FSM and multiply path stay in `ex_muldiv`.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DIVU 100/7, start at cycle 0 -> `stall_req_out`=1 for cycles 0..32; `hilo_we_out` at cycle 33; LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF x 0xFFFFFFFF -> HILO=0x0000000000000001; MULTU same operands -> HILO=0xFFFFFFFE00000001. Latency 33 without `MULDIV_FAST_MUL_EN`, 1 with it.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, no hang.
- `flush_in` at cycle 10 of a DIV -> IDLE at cycle 11, `hilo_we_out` never asserted, HILO_out unchanged; then a new DIVU 9/3 gives LO=3, HI=0.
- `rset` low at cycle 20 of MULTU -> outputs 0 immediately (asynchronously); after release, `start_in` gives a correct result.
